// File: rtl/compare_pkg.sv
// Shared types for the serial magnitude comparator: FSM encoding, result flags
// and the default operand width.
package compare_pkg;

    localparam int unsigned CMP_WIDTH_DEFAULT = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } cmp_state_t;

    typedef struct packed {
        logic greater;
        logic equal;
        logic smaller;
    } cmp_result_t;

    localparam cmp_result_t RES_NONE = '{greater: 1'b0, equal: 1'b0, smaller: 1'b0};
    localparam cmp_result_t RES_GT   = '{greater: 1'b1, equal: 1'b0, smaller: 1'b0};
    localparam cmp_result_t RES_EQ   = '{greater: 1'b0, equal: 1'b1, smaller: 1'b0};
    localparam cmp_result_t RES_LT   = '{greater: 1'b0, equal: 1'b0, smaller: 1'b1};

endpackage

// File: rtl/compare_bit_step.sv
// Single-bit decision of the serial comparator: do the bits differ, and if so
// is A the larger operand (the sign bit flips the sense in signed mode).
module compare_bit_step (
    input  logic i_bit_a,
    input  logic i_bit_b,
    input  logic i_is_msb,
    input  logic i_signed_mode,
    output logic o_differ_c,
    output logic o_a_gt_c
);

    always_comb begin
        o_differ_c = i_bit_a ^ i_bit_b;
        o_a_gt_c   = (i_is_msb && i_signed_mode) ? i_bit_b : i_bit_a;
    end

endmodule

// File: rtl/compare_nbit_serial.sv
// Serial MSB-first comparator of two captured operands, one bit per cycle,
// terminating early on the first differing bit.
module compare_nbit_serial
    import compare_pkg::*;
#(
    parameter int unsigned CMP_WIDTH = CMP_WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [CMP_WIDTH-1:0] a,
    input  logic [CMP_WIDTH-1:0] b,
    output logic                 busy,
    output logic                 done,
    output logic                 greater,
    output logic                 equal,
    output logic                 smaller
);

    localparam int unsigned IDX_W = $clog2(CMP_WIDTH);

    cmp_state_t           r_state;
    logic [IDX_W-1:0]     r_idx;
    logic [CMP_WIDTH-1:0] r_a;
    logic [CMP_WIDTH-1:0] r_b;
    logic                 r_signed;
    cmp_result_t          r_res;
    logic                 r_busy;
    logic                 r_done;

    cmp_state_t           w_state_next;
    logic [IDX_W-1:0]     w_idx_next;
    logic [CMP_WIDTH-1:0] w_a_next;
    logic [CMP_WIDTH-1:0] w_b_next;
    logic                 w_signed_next;
    cmp_result_t          w_res_next;
    logic                 w_is_msb;
    logic                 w_differ;
    logic                 w_a_gt;

    assign w_is_msb = (r_idx == IDX_W'(CMP_WIDTH - 1));

    compare_bit_step u_bit_step (
        .i_bit_a       (r_a[r_idx]),
        .i_bit_b       (r_b[r_idx]),
        .i_is_msb      (w_is_msb),
        .i_signed_mode (r_signed),
        .o_differ_c    (w_differ),
        .o_a_gt_c      (w_a_gt)
    );

    // State, captured operands and results; busy/done registered from next state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_idx    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_signed <= 1'b0;
            r_res    <= RES_NONE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_idx    <= w_idx_next;
            r_a      <= w_a_next;
            r_b      <= w_b_next;
            r_signed <= w_signed_next;
            r_res    <= w_res_next;
            r_busy   <= (w_state_next == ST_SCAN);
            r_done   <= (w_state_next == ST_DONE);
        end
    end

    // Next-state, capture and decision logic
    always_comb begin
        w_state_next  = r_state;
        w_idx_next    = r_idx;
        w_a_next      = r_a;
        w_b_next      = r_b;
        w_signed_next = r_signed;
        w_res_next    = r_res;

        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_state_next  = ST_SCAN;
                    w_idx_next    = IDX_W'(CMP_WIDTH - 1);
                    w_a_next      = a;
                    w_b_next      = b;
                    w_signed_next = signed_mode;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (w_differ) begin
                    w_state_next = ST_DONE;
                    w_res_next   = w_a_gt ? RES_GT : RES_LT;
                end else if (r_idx == '0) begin
                    w_state_next = ST_DONE;
                    w_res_next   = RES_EQ;
                end else begin
                    w_idx_next = r_idx - IDX_W'(1);
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign greater = r_res.greater;
    assign equal   = r_res.equal;
    assign smaller = r_res.smaller;

endmodule

// File: tb/tb_compare_nbit_serial.sv
// Directed bench for compare_nbit_serial at CMP_WIDTH=5: vector table plus
// hand sequences for held start, back-to-back launch and mid-scan reset.
module tb_compare_nbit_serial;

    localparam int unsigned W = 5;

    logic         clk;
    logic         reset;
    logic         start;
    logic         signed_mode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic         greater;
    logic         equal;
    logic         smaller;

    int n_checks;
    int n_fail;

    compare_nbit_serial #(.CMP_WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .signed_mode (signed_mode),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .greater     (greater),
        .equal       (equal),
        .smaller     (smaller)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic         sm;
        logic         g;
        logic         e;
        logic         s;
        int           edges;   // edges from the accepting edge (inclusive) until done is seen
        string        name;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Clock edges until done; inputs are changed and outputs sampled 1ns after each edge
    task automatic wait_done(input bit hold, input bit scramble,
                             output int edges, output int busy_n, output bit ok);
        edges  = 0;
        busy_n = 0;
        ok     = 1'b0;
        for (int n = 1; n <= 50; n++) begin
            @(posedge clk);
            #1;
            if (!hold) start = 1'b0;
            if (scramble) begin
                a = a + 5'd7;
                b = b ^ 5'd21;
            end
            if (busy) busy_n++;
            if (done) begin
                edges = n;
                ok    = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_vec(input vec_t v);
        int edges;
        int busy_n;
        bit ok;
        a           = v.va;
        b           = v.vb;
        signed_mode = v.sm;
        start       = 1'b1;
        wait_done(1'b0, 1'b0, edges, busy_n, ok);
        check({v.name, " done_seen"}, int'(ok), 1);
        check({v.name, " latency"}, edges, v.edges);
        check({v.name, " busy_cycles"}, busy_n, v.edges - 1);
        check({v.name, " greater"}, int'(greater), int'(v.g));
        check({v.name, " equal"}, int'(equal), int'(v.e));
        check({v.name, " smaller"}, int'(smaller), int'(v.s));
        @(posedge clk);
        #1;
        check({v.name, " done_pulse_end"}, int'(done), 0);
        check({v.name, " busy_after"}, int'(busy), 0);
        check({v.name, " held"}, int'({greater, equal, smaller}), int'({v.g, v.e, v.s}));
    endtask

    initial begin
        int edges;
        int busy_n;
        bit ok;
        int done_seen;

        n_checks = 0;
        n_fail   = 0;

        vecs[0] = '{5'd3,  5'd2,  1'b0, 1'b1, 1'b0, 1'b0, 6, "u_3_gt_2"};
        vecs[1] = '{5'd9,  5'd11, 1'b0, 1'b0, 1'b0, 1'b1, 5, "u_9_lt_11"};
        vecs[2] = '{5'd3,  5'd3,  1'b0, 1'b0, 1'b1, 1'b0, 6, "u_3_eq_3"};
        vecs[3] = '{5'd31, 5'd1,  1'b1, 1'b0, 1'b0, 1'b1, 2, "s_m1_lt_1"};
        vecs[4] = '{5'd31, 5'd1,  1'b0, 1'b1, 1'b0, 1'b0, 2, "u_31_gt_1"};
        vecs[5] = '{5'd16, 5'd15, 1'b1, 1'b0, 1'b0, 1'b1, 2, "s_m16_lt_15"};
        vecs[6] = '{5'd0,  5'd31, 1'b1, 1'b1, 1'b0, 1'b0, 2, "s_0_gt_m1"};
        vecs[7] = '{5'd20, 5'd21, 1'b1, 1'b0, 1'b0, 1'b1, 6, "s_m12_lt_m11"};
        vecs[8] = '{5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 6, "u_0_eq_0"};
        vecs[9] = '{5'd8,  5'd4,  1'b0, 1'b1, 1'b0, 1'b0, 3, "u_8_gt_4"};

        reset       = 1'b1;
        start       = 1'b0;
        signed_mode = 1'b0;
        a           = '0;
        b           = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset greater", int'(greater), 0);
        check("reset equal", int'(equal), 0);
        check("reset smaller", int'(smaller), 0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Start held through SCAN while operands change; DONE-cycle start launches next compare
        a           = 5'd3;
        b           = 5'd2;
        signed_mode = 1'b0;
        start       = 1'b1;
        wait_done(1'b1, 1'b1, edges, busy_n, ok);
        check("hold done_seen", int'(ok), 1);
        check("hold latency", edges, 6);
        check("hold busy_cycles", busy_n, 5);
        check("hold greater", int'(greater), 1);
        check("hold smaller", int'(smaller), 0);
        a = 5'd9;
        b = 5'd11;
        wait_done(1'b0, 1'b0, edges, busy_n, ok);
        check("b2b done_seen", int'(ok), 1);
        check("b2b latency", edges, 5);
        check("b2b busy_cycles", busy_n, 4);
        check("b2b smaller", int'(smaller), 1);
        check("b2b greater", int'(greater), 0);
        @(posedge clk);
        #1;
        check("b2b done_pulse_end", int'(done), 0);

        // Reset in the second SCAN cycle aborts without a done pulse
        a     = 5'd3;
        b     = 5'd2;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("abort scan1 busy", int'(busy), 1);
        @(posedge clk);
        #1;
        check("abort scan2 busy", int'(busy), 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort busy", int'(busy), 0);
        check("abort done", int'(done), 0);
        check("abort flags", int'({greater, equal, smaller}), 0);
        done_seen = 0;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk);
            #1;
            if (done || busy) done_seen++;
        end
        check("abort no_done", done_seen, 0);
        run_vec(vecs[1]);

        // Reset wins over a simultaneous start
        reset = 1'b1;
        start = 1'b1;
        a     = 5'd3;
        b     = 5'd2;
        @(posedge clk);
        #1;
        reset = 1'b0;
        start = 1'b0;
        check("prio busy", int'(busy), 0);
        check("prio flags", int'({greater, equal, smaller}), 0);
        done_seen = 0;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk);
            #1;
            if (done || busy) done_seen++;
        end
        check("prio no_activity", done_seen, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
